// File: rtl/nf2_dma_pkg.sv
// rtl/nf2_dma_pkg.sv - shared op codes, status-word layout and direction encoding for the NF2 DMA scheduler
package nf2_dma_pkg;

    localparam logic [1:0] OP_CODE_IDLE  = 2'b00;
    localparam logic [1:0] OP_CODE_QUERY = 2'b01;
    localparam logic [1:0] OP_CODE_C2N   = 2'b10;
    localparam logic [1:0] OP_CODE_N2C   = 2'b11;

    localparam int PKT_AVAIL_LSB   = 16;
    localparam int NEARLY_FULL_LSB = 0;
    localparam int QID_W           = 4;

    typedef enum logic {
        DIR_C2N = 1'b0,
        DIR_N2C = 1'b1
    } xfer_dir_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUERY,
        ST_ARB,
        ST_REQ,
        ST_XFER,
        ST_GAP
    } sched_state_e;

    // Round-robin pointer step: one past the granted queue, wrapping at n-1.
    function automatic logic [QID_W-1:0] rr_next(input logic [QID_W-1:0] id, input int n);
        return (int'(id) >= n - 1) ? '0 : id + QID_W'(1);
    endfunction

endpackage

// File: rtl/nf2_dma_xfer_sched_if.sv
// rtl/nf2_dma_xfer_sched_if.sv - NF2 DMA engine op-code/status bus
interface nf2_dma_xfer_sched_if #(
    parameter int DW = 32
);
    logic [1:0]    dma_op_code_req;
    logic [3:0]    dma_op_queue_id;
    logic [1:0]    dma_op_code_ack;
    logic          dma_vld_n2c;
    logic [DW-1:0] dma_data_n2c;

    modport master (
        output dma_op_code_req,
        output dma_op_queue_id,
        input  dma_op_code_ack,
        input  dma_vld_n2c,
        input  dma_data_n2c
    );

    modport slave (
        input  dma_op_code_req,
        input  dma_op_queue_id,
        output dma_op_code_ack,
        output dma_vld_n2c,
        output dma_data_n2c
    );
endinterface

// File: rtl/nf2_rr_arbiter.sv
// rtl/nf2_rr_arbiter.sv - combinational round-robin pick starting at ptr
module nf2_rr_arbiter
    import nf2_dma_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [QID_W-1:0] ptr,
    output logic [QID_W-1:0] grant_id,
    output logic             grant_vld
);

    logic [N-1:0] rot;

    // Rotate requests so that bit 0 is the queue at ptr, find the nearest one, then un-rotate.
    always_comb begin
        int off;
        int sum;
        rot       = N'({req, req} >> ptr);
        off       = 0;
        grant_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off       = i;
                grant_vld = 1'b1;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        grant_id = grant_vld ? QID_W'(sum) : '0;
    end

endmodule

// File: rtl/nf2_dma_xfer_sched.sv
// rtl/nf2_dma_xfer_sched.sv - host-side NF2 DMA poll/arbitrate/grant scheduler
module nf2_dma_xfer_sched
    import nf2_dma_pkg::*;
#(
    parameter int NUM_CPU_QUEUES = 4,
    parameter int DMA_DATA_WIDTH = 32,
    parameter int ACK_TIMEOUT    = 255,
    parameter int QUERY_GAP      = 16
) (
    input  logic                      cpci_clk,
    input  logic                      cpci_reset,
    input  logic                      enable_dma,
    nf2_dma_xfer_sched_if.master      dma,
    input  logic [NUM_CPU_QUEUES-1:0] host_tx_req,
    input  logic                      host_rx_rdy,
    output logic                      xfer_start,
    output logic                      xfer_dir,
    output logic [3:0]                xfer_qid,
    input  logic                      xfer_done,
    output logic [NUM_CPU_QUEUES-1:0] q_pkt_avail,
    output logic [NUM_CPU_QUEUES-1:0] q_nearly_full,
    output logic                      timeout_err
);

    localparam int NQ = NUM_CPU_QUEUES;

    sched_state_e            state;
    xfer_dir_e               last_dir;
    logic [7:0]              timer;
    logic [7:0]              gap_cnt;
    logic [QID_W-1:0]        ptr_c2n, ptr_n2c;
    logic [NQ-1:0]           elig_c2n, elig_n2c;
    logic [QID_W-1:0]        c2n_id, n2c_id;
    logic                    c2n_vld, n2c_vld, take_n2c;
    logic [DMA_DATA_WIDTH-1:0] status_word;
    logic                    unused_status;
    logic                    status_hit;

    assign status_word   = dma.dma_data_n2c;
    assign unused_status = ^status_word;
    assign status_hit    = (dma.dma_op_code_ack == OP_CODE_QUERY) && dma.dma_vld_n2c;

    // Eligibility comes from the last captured status, so it is stable through ARB.
    assign elig_n2c = q_pkt_avail & {NQ{host_rx_rdy}};
    assign elig_c2n = host_tx_req & ~q_nearly_full;
    assign take_n2c = n2c_vld && (!c2n_vld || last_dir == DIR_C2N);

    nf2_rr_arbiter #(.N(NQ)) u_arb_c2n (
        .req       (elig_c2n),
        .ptr       (ptr_c2n),
        .grant_id  (c2n_id),
        .grant_vld (c2n_vld)
    );

    nf2_rr_arbiter #(.N(NQ)) u_arb_n2c (
        .req       (elig_n2c),
        .ptr       (ptr_n2c),
        .grant_id  (n2c_id),
        .grant_vld (n2c_vld)
    );

    // Scheduler FSM: poll, arbitrate, request, hold for the data mover, with ack timeouts.
    always_ff @(posedge cpci_clk) begin
        if (cpci_reset) begin
            state               <= ST_IDLE;
            last_dir            <= DIR_N2C;
            timer               <= '0;
            gap_cnt             <= '0;
            ptr_c2n             <= '0;
            ptr_n2c             <= '0;
            dma.dma_op_code_req <= OP_CODE_IDLE;
            dma.dma_op_queue_id <= '0;
            xfer_start          <= 1'b0;
            xfer_dir            <= 1'b0;
            xfer_qid            <= '0;
            q_pkt_avail         <= '0;
            q_nearly_full       <= '0;
            timeout_err         <= 1'b0;
        end else begin
            xfer_start  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dma.dma_op_code_req <= OP_CODE_IDLE;
                    dma.dma_op_queue_id <= '0;
                    if (enable_dma) begin
                        state               <= ST_QUERY;
                        dma.dma_op_code_req <= OP_CODE_QUERY;
                        timer               <= '0;
                    end
                end
                ST_QUERY: begin
                    if (!enable_dma) begin
                        state               <= ST_IDLE;
                        dma.dma_op_code_req <= OP_CODE_IDLE;
                    end else if (status_hit) begin
                        q_pkt_avail   <= status_word[PKT_AVAIL_LSB +: NQ];
                        q_nearly_full <= status_word[NEARLY_FULL_LSB +: NQ];
                        state         <= ST_ARB;
                    end else if (timer == 8'(ACK_TIMEOUT)) begin
                        state               <= ST_IDLE;
                        dma.dma_op_code_req <= OP_CODE_IDLE;
                        timeout_err         <= 1'b1;
                    end else begin
                        timer <= (timer == 8'hFF) ? timer : timer + 8'd1;
                    end
                end
                ST_ARB: begin
                    if (!enable_dma) begin
                        state               <= ST_IDLE;
                        dma.dma_op_code_req <= OP_CODE_IDLE;
                    end else if (!c2n_vld && !n2c_vld) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end else begin
                        state <= ST_REQ;
                        timer <= '0;
                        if (take_n2c) begin
                            dma.dma_op_code_req <= OP_CODE_N2C;
                            dma.dma_op_queue_id <= n2c_id;
                            ptr_n2c             <= rr_next(n2c_id, NQ);
                            last_dir            <= DIR_N2C;
                        end else begin
                            dma.dma_op_code_req <= OP_CODE_C2N;
                            dma.dma_op_queue_id <= c2n_id;
                            ptr_c2n             <= rr_next(c2n_id, NQ);
                            last_dir            <= DIR_C2N;
                        end
                    end
                end
                ST_REQ: begin
                    if (dma.dma_op_code_ack == dma.dma_op_code_req) begin
                        state      <= ST_XFER;
                        xfer_start <= 1'b1;
                        xfer_dir   <= (dma.dma_op_code_req == OP_CODE_N2C);
                        xfer_qid   <= dma.dma_op_queue_id;
                    end else if (timer == 8'(ACK_TIMEOUT)) begin
                        state               <= ST_IDLE;
                        dma.dma_op_code_req <= OP_CODE_IDLE;
                        dma.dma_op_queue_id <= '0;
                        timeout_err         <= 1'b1;
                    end else begin
                        timer <= (timer == 8'hFF) ? timer : timer + 8'd1;
                    end
                end
                ST_XFER: begin
                    if (xfer_done) begin
                        state               <= ST_QUERY;
                        dma.dma_op_code_req <= OP_CODE_QUERY;
                        dma.dma_op_queue_id <= '0;
                        xfer_dir            <= 1'b0;
                        xfer_qid            <= '0;
                        timer               <= '0;
                    end
                end
                ST_GAP: begin
                    if (!enable_dma) begin
                        state               <= ST_IDLE;
                        dma.dma_op_code_req <= OP_CODE_IDLE;
                    end else if (gap_cnt == 8'(QUERY_GAP - 1)) begin
                        state <= ST_QUERY;
                        timer <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state               <= ST_IDLE;
                    dma.dma_op_code_req <= OP_CODE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nf2_dma_xfer_sched.sv
// tb/tb_nf2_dma_xfer_sched.sv - self-checking bench for nf2_dma_xfer_sched
module tb_nf2_dma_xfer_sched;
    import nf2_dma_pkg::*;

    localparam int NQ     = 4;
    localparam int DW     = 32;
    localparam int ACK_TO = 255;
    localparam int QGAP   = 16;
    localparam int NV     = 13;

    logic          cpci_clk = 1'b0;
    logic          cpci_reset = 1'b1;
    logic          enable_dma = 1'b0;
    logic [NQ-1:0] host_tx_req = '0;
    logic          host_rx_rdy = 1'b0;
    logic          xfer_start, xfer_dir;
    logic [3:0]    xfer_qid;
    logic          xfer_done = 1'b0;
    logic [NQ-1:0] q_pkt_avail, q_nearly_full;
    logic          timeout_err;
    logic [DW-1:0] status_word = '0;
    bit            block_c2n = 1'b0;
    bit            mover_hold = 1'b0;
    int            start_cnt = 0, done_cnt = 0, stray_req = 0, stray_ack = 0;
    int            n_checks = 0, n_fail = 0;

    always #5 cpci_clk = ~cpci_clk;

    nf2_dma_xfer_sched_if #(.DW(DW)) dma_if ();

    nf2_dma_xfer_sched #(
        .NUM_CPU_QUEUES (NQ),
        .DMA_DATA_WIDTH (DW),
        .ACK_TIMEOUT    (ACK_TO),
        .QUERY_GAP      (QGAP)
    ) dut (
        .cpci_clk      (cpci_clk),
        .cpci_reset    (cpci_reset),
        .enable_dma    (enable_dma),
        .dma           (dma_if),
        .host_tx_req   (host_tx_req),
        .host_rx_rdy   (host_rx_rdy),
        .xfer_start    (xfer_start),
        .xfer_dir      (xfer_dir),
        .xfer_qid      (xfer_qid),
        .xfer_done     (xfer_done),
        .q_pkt_avail   (q_pkt_avail),
        .q_nearly_full (q_nearly_full),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        bit            rst_before;
        logic [NQ-1:0] pkt;
        logic [NQ-1:0] nf;
        logic [NQ-1:0] tx;
        logic          rx_rdy;
        logic          exp_dir;
        logic [3:0]    exp_qid;
    } vec_t;

    typedef struct {
        logic       dir;
        logic [3:0] qid;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb_q[$];

    // DMA engine model: echoes the op code one cycle later, returns status with every query ack.
    always @(negedge cpci_clk) begin
        if (block_c2n && dma_if.dma_op_code_req == OP_CODE_C2N)
            dma_if.dma_op_code_ack = OP_CODE_IDLE;
        else
            dma_if.dma_op_code_ack = dma_if.dma_op_code_req;
        dma_if.dma_vld_n2c  = (dma_if.dma_op_code_req == OP_CODE_QUERY);
        dma_if.dma_data_n2c = status_word;
    end

    // Data mover model: finishes each granted transfer three cycles after xfer_start.
    always @(negedge cpci_clk) begin
        xfer_done = 1'b0;
        if (stray_req != stray_ack) begin
            stray_ack = stray_ack + 1;
            xfer_done = 1'b1;
        end else if (done_cnt > 0) begin
            done_cnt = done_cnt - 1;
            if (done_cnt == 0) xfer_done = 1'b1;
        end
        if (xfer_start && !cpci_reset) begin
            start_cnt = start_cnt + 1;
            if (!mover_hold) done_cnt = 3;
        end
    end

    function automatic logic [DW-1:0] mk_status(input logic [NQ-1:0] pkt, input logic [NQ-1:0] nf);
        return (DW'(pkt) << PKT_AVAIL_LSB) | (DW'(nf) << NEARLY_FULL_LSB);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        cpci_reset = 1'b1;
        repeat (3) @(negedge cpci_clk);
        cpci_reset = 1'b0;
    endtask

    task automatic expect_start(input logic dir, input logic [3:0] qid);
        exp_t e;
        exp_t got;
        int   n;
        e.dir = dir;
        e.qid = qid;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge cpci_clk);
            n++;
        end while (!xfer_start && n < 1000);
        check("start_seen", xfer_start, 1'b1);
        got = sb_q.pop_front();
        check("start_dir", xfer_dir, got.dir);
        check("start_qid", xfer_qid, got.qid);
        check("start_op_qid", dma_if.dma_op_queue_id, got.qid);
        check("start_op_code", dma_if.dma_op_code_req, got.dir ? OP_CODE_N2C : OP_CODE_C2N);
    endtask

    initial begin
        int n;
        int s0;

        // rst, pkt, nf, tx, rx_rdy, dir, qid
        vecs[0] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, DIR_N2C, 4'd2};
        vecs[1] = '{1'b0, 4'b0000, 4'b0001, 4'b1001, 1'b1, DIR_C2N, 4'd3};
        vecs[2] = '{1'b0, 4'b0000, 4'b0001, 4'b1001, 1'b1, DIR_C2N, 4'd3};
        vecs[3] = '{1'b0, 4'b0001, 4'b0000, 4'b0010, 1'b0, DIR_C2N, 4'd1};
        vecs[4] = '{1'b0, 4'b0011, 4'b0000, 4'b0000, 1'b1, DIR_N2C, 4'd0};
        for (int i = 0; i < 8; i++) begin
            vecs[5 + i] = '{(i == 0), 4'b1111, 4'b0000, 4'b1111, 1'b1,
                            (i % 2 == 1) ? DIR_N2C : DIR_C2N, 4'(i / 2)};
        end

        do_reset();
        check("rst_op_code", dma_if.dma_op_code_req, OP_CODE_IDLE);
        check("rst_op_qid", dma_if.dma_op_queue_id, 4'd0);
        check("rst_xfer_start", xfer_start, 1'b0);
        check("rst_xfer_dir", xfer_dir, 1'b0);
        check("rst_xfer_qid", xfer_qid, 4'd0);
        check("rst_pkt_avail", q_pkt_avail, 4'd0);
        check("rst_nearly_full", q_nearly_full, 4'd0);
        check("rst_timeout", timeout_err, 1'b0);
        repeat (3) @(negedge cpci_clk);
        check("idle_no_enable", dma_if.dma_op_code_req, OP_CODE_IDLE);

        enable_dma = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst_before) begin
                enable_dma  = 1'b0;
                host_tx_req = '0;
                repeat (10) @(negedge cpci_clk);
                do_reset();
                enable_dma = 1'b1;
            end
            host_tx_req = vecs[i].tx;
            host_rx_rdy = vecs[i].rx_rdy;
            status_word = mk_status(vecs[i].pkt, vecs[i].nf);
            expect_start(vecs[i].exp_dir, vecs[i].exp_qid);
        end

        // Ack timeout on a C2N request that the engine never echoes.
        enable_dma  = 1'b0;
        host_tx_req = '0;
        repeat (10) @(negedge cpci_clk);
        do_reset();
        s0          = start_cnt;
        block_c2n   = 1'b1;
        host_tx_req = 4'b0001;
        status_word = mk_status(4'b0000, 4'b0000);
        enable_dma  = 1'b1;
        n = 0;
        while (dma_if.dma_op_code_req != OP_CODE_C2N && n < 50) begin
            @(negedge cpci_clk);
            n++;
        end
        check("to_req_issued", dma_if.dma_op_code_req, OP_CODE_C2N);
        n = 0;
        while (!timeout_err && n < 400) begin
            @(negedge cpci_clk);
            n++;
        end
        check("to_pulse_seen", timeout_err, 1'b1);
        check_range("to_latency", n, ACK_TO, ACK_TO + 1);
        check("to_op_idle", dma_if.dma_op_code_req, OP_CODE_IDLE);
        @(negedge cpci_clk);
        check("to_pulse_width", timeout_err, 1'b0);
        check("to_requery", dma_if.dma_op_code_req, OP_CODE_QUERY);
        check("to_no_start", start_cnt, s0);

        // Nothing eligible: poll gap, then enable_dma dropped while idling in the gap.
        enable_dma  = 1'b0;
        block_c2n   = 1'b0;
        host_tx_req = '0;
        repeat (10) @(negedge cpci_clk);
        do_reset();
        s0          = start_cnt;
        status_word = mk_status(4'b0000, 4'b0001);
        enable_dma  = 1'b1;
        n = 0;
        while (q_nearly_full != 4'b0001 && n < 50) begin
            @(negedge cpci_clk);
            n++;
        end
        check("gap_first_capture", q_nearly_full, 4'b0001);
        status_word = mk_status(4'b0000, 4'b0010);
        n = 0;
        while (q_nearly_full != 4'b0010 && n < 100) begin
            @(negedge cpci_clk);
            n++;
        end
        check("gap_second_capture", q_nearly_full, 4'b0010);
        check_range("gap_interval", n, QGAP, QGAP + 3);
        check("gap_no_start", start_cnt, s0);
        repeat (3) @(negedge cpci_clk);
        enable_dma = 1'b0;
        repeat (2) @(negedge cpci_clk);
        check("gap_disable_idle", dma_if.dma_op_code_req, OP_CODE_IDLE);
        repeat (5) @(negedge cpci_clk);
        check("gap_stays_idle", dma_if.dma_op_code_req, OP_CODE_IDLE);

        // Reset while a transfer is in flight, then a stray xfer_done.
        do_reset();
        mover_hold  = 1'b1;
        host_rx_rdy = 1'b1;
        host_tx_req = '0;
        status_word = mk_status(4'b0100, 4'b0000);
        enable_dma  = 1'b1;
        expect_start(DIR_N2C, 4'd2);
        @(negedge cpci_clk);
        check("xfer_op_held", dma_if.dma_op_code_req, OP_CODE_N2C);
        check("xfer_qid_held", dma_if.dma_op_queue_id, 4'd2);
        cpci_reset = 1'b1;
        enable_dma = 1'b0;
        @(negedge cpci_clk);
        check("mid_rst_op", dma_if.dma_op_code_req, OP_CODE_IDLE);
        check("mid_rst_op_qid", dma_if.dma_op_queue_id, 4'd0);
        check("mid_rst_dir", xfer_dir, 1'b0);
        check("mid_rst_qid", xfer_qid, 4'd0);
        check("mid_rst_pkt", q_pkt_avail, 4'd0);
        cpci_reset = 1'b0;
        mover_hold = 1'b0;
        s0         = start_cnt;
        stray_req  = stray_req + 1;
        repeat (5) @(negedge cpci_clk);
        check("stray_done_op", dma_if.dma_op_code_req, OP_CODE_IDLE);
        check("stray_done_start", start_cnt, s0);
        enable_dma = 1'b1;
        expect_start(DIR_N2C, 4'd2);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
